life_automaton: RTL and testbench
=================================

# life_automaton

Parametrised cellular-automaton engine: the next generation of the team's fixed-rule 16x16 Game-of-Life array. It holds a ROWS x COLS cell grid and advances it one generation per clock using any outer-totalistic "life-like" rule, given as birth/survive masks. It adds selectable toroidal or dead-edge boundaries, run/stop/single-step control and a saturating generation counter. It also detects still-life and extinction, with optional automatic halt. It sits between the pattern loader (data/load) and the display/readout logic (q, status).

## Interface

- ROWS, 16, grid rows (>=3)
- COLS, 16, grid columns (>=3)
- GEN_W, 16, generation counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  load grid from data
- data  in  ROWS*COLS  initial pattern; bit r*COLS+c = cell (row r, col c)
- start  in  1  enter free-running mode
- stop  in  1  leave free-running mode
- step  in  1  advance exactly one generation (idle only)
- birth_mask  in  9  bit n=1: dead cell with n live neighbours becomes live
- survive_mask  in  9  bit n=1: live cell with n live neighbours stays live
- wrap  in  1  1 = toroidal edges, 0 = out-of-grid neighbours count as dead
- auto_halt  in  1  1 = leave RUN automatically on stable or extinct
- q  out  ROWS*COLS  current grid, registered
- gen_count  out  GEN_W  generations since last load, saturating
- running  out  1  1 while in RUN
- stable  out  1  last update produced q_next == q
- extinct  out  1  last update produced an all-zero grid

## Operation

- States: IDLE, RUN. running = (state == RUN).
- Neighbour count n per cell: 4-bit sum of the 8 neighbours, range 0..8.
  - wrap=1: row/col indices wrap modulo ROWS/COLS.
  - wrap=0: neighbours off the grid contribute 0.
- Next cell value = cell ? survive_mask[n] : birth_mask[n].
- Masks and wrap are sampled combinationally at every update. A change takes effect at the next update.
- Priority per edge: load > stop > step/start.
- load (any state):
  - q <= data; gen_count <= 0; stable <= 0; extinct <= 0; state <= IDLE.
  - start, step and stop are ignored that cycle.
- stop: state <= IDLE; no update that edge.
- IDLE, step=1: one update; state stays IDLE. Both step and start high: start wins, no update that edge.
- IDLE, start=1: state <= RUN; no update that edge.
- RUN: one update every edge. start and step are ignored.
- Update:
  - q <= q_next; gen_count <= gen_count+1, holding at 2^GEN_W-1.
  - stable <= (q_next == q); extinct <= (q_next == 0).
- Auto-halt: in RUN with auto_halt=1, an update that sets stable or extinct also sets state <= IDLE on the same edge.
- stable and extinct hold their value until the next update or load.

## Timing

- Reset (async assert, sync release): q=0, gen_count=0, state=IDLE, running=0, stable=0, extinct=0.
- Reset mid-run aborts immediately; the grid is lost.
- load at edge N: q=data, gen_count=0 visible after N.
- step at edge N (IDLE): updated q and gen_count+1 visible after N (latency 1).
- start at edge N: running=1 after N; first update at edge N+1; updates continue every edge.
- stop at edge N: running=0 after N; q unchanged at N.
- Auto-halt: the triggering update at edge N also clears running after N. q is the final grid.
- Single combinational generation per cycle; no pipelining. q_next depends only on registered q.

## Test plan

- Conway rule (birth_mask=9'h008, survive_mask=9'h00C), wrap=0, 5x5, blinker on row 2 cols 1-3; step x2.
  - Required: vertical col 2 rows 1-3, then back to horizontal; gen_count=2; stable=0.
- Same rule, 8x8, wrap=1, glider; start, stop after 32 updates.
  - Required: q equals the initial pattern; gen_count=32.
  - Same glider with wrap=0: dies against the edge as a 2x2 block; extinct=0 and stable=1 once the block forms.
- 2x2 block, auto_halt=1, start.
  - Required: after first update stable=1, running=0, gen_count=1, q unchanged.
- Single live cell, step.
  - Required: q=0, extinct=1, stable=0.
  - Second step: stable=1, extinct=1, gen_count=2.
- HighLife (birth_mask=9'h048), 6 live cells arranged to give a dead cell exactly 6 neighbours; step.
  - Required: that cell is born under HighLife and not under the Conway mask.
- GEN_W=3, blinker, start, run 10 edges.
  - Required: gen_count holds at 7.
  - Then assert rst_n=0 mid-run: q=0, gen_count=0, running=0 immediately, with no clock edge.
  - load while running: running=0, q=data.

Source files
------------

// File: rtl/life_automaton.sv
// Life-like cellular automaton: ROWS x COLS grid, one generation per clock, birth/survive rule masks.
// Latency 1 (q visible the edge after load/step); no backpressure, control is level-sampled each edge.
module life_automaton #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] data,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  input  logic [8:0]           birth_mask,
  input  logic [8:0]           survive_mask,
  input  logic                 wrap,
  input  logic                 auto_halt,
  output logic [ROWS*COLS-1:0] q,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 stable,
  output logic                 extinct
);

  localparam int N = ROWS * COLS;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]   state;
  logic [N-1:0] q_next;
  logic         do_update;
  logic         next_stable;
  logic         next_extinct;

  // Off-grid neighbours are either wrapped around (torus) or treated as dead.
  function automatic logic [3:0] nbr_count(input logic [N-1:0] g, input int r, input int c,
                                           input logic w);
    logic [3:0] n;
    int rr;
    int cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (!(dr == 0 && dc == 0)) begin
          if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
            n = n + {3'b000, g[rr*COLS+cc]};
          else if (w)
            n = n + {3'b000, g[((rr + ROWS) % ROWS)*COLS + ((cc + COLS) % COLS)]};
        end
      end
    end
    return n;
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] n;
      assign n = nbr_count(q, r, c, wrap);
      assign q_next[r*COLS+c] = q[r*COLS+c] ? survive_mask[n] : birth_mask[n];
    end
  end

  assign next_stable  = (q_next == q);
  assign next_extinct = (q_next == '0);
  assign running      = (state == S_RUN);

  // start beats step in IDLE, so a simultaneous start/step does not update.
  always_comb begin
    do_update = 1'b0;
    if (!load && !stop) begin
      if (state == S_RUN) do_update = 1'b1;
      else                do_update = step && !start;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
      state     <= S_IDLE;
    end else if (load) begin
      q         <= data;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
      state     <= S_IDLE;
    end else if (stop) begin
      state <= S_IDLE;
    end else begin
      if (state == S_IDLE && start) state <= S_RUN;
      if (do_update) begin
        q         <= q_next;
        gen_count <= (gen_count == '1) ? gen_count : gen_count + GEN_W'(1);
        stable    <= next_stable;
        extinct   <= next_extinct;
        if (state == S_RUN && auto_halt && (next_stable || next_extinct)) state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_life_automaton.sv
// Directed bench: an 8x8 instance (GEN_W=16) and a 5x5 instance (GEN_W=3) sharing control inputs.
module tb_life_automaton;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [8:0]  birth_mask = 9'h008, survive_mask = 9'h00C;
  logic        wrap = 1'b0, auto_halt = 1'b0;
  logic [63:0] data_a = '0;
  logic [24:0] data_b = '0;
  logic [63:0] q_a;
  logic [24:0] q_b;
  logic [15:0] gen_a;
  logic [2:0]  gen_b;
  logic        run_a, run_b, stable_a, stable_b, extinct_a, extinct_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  life_automaton #(.ROWS(8), .COLS(8), .GEN_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data_a), .start(start), .stop(stop),
    .step(step), .birth_mask(birth_mask), .survive_mask(survive_mask), .wrap(wrap),
    .auto_halt(auto_halt), .q(q_a), .gen_count(gen_a), .running(run_a), .stable(stable_a),
    .extinct(extinct_a));

  life_automaton #(.ROWS(5), .COLS(5), .GEN_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data_b), .start(start), .stop(stop),
    .step(step), .birth_mask(birth_mask), .survive_mask(survive_mask), .wrap(wrap),
    .auto_halt(auto_halt), .q(q_b), .gen_count(gen_b), .running(run_b), .stable(stable_b),
    .extinct(extinct_b));

  typedef struct {
    logic [63:0] data;
    logic [8:0]  birth;
    logic [8:0]  survive;
    logic        wrap;
    logic [63:0] exp_q;
    logic        exp_stable;
    logic        exp_extinct;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    // Row r of the 8x8 grid is byte r of the 64-bit word (col c = bit c of that byte).
    vecs[0] = '{64'h0000_0000_0800_0000, 9'h008, 9'h00C, 1'b0, 64'h0, 1'b0, 1'b1};
    vecs[1] = '{64'h0000_0018_1800_0000, 9'h008, 9'h00C, 1'b0, 64'h0000_0018_1800_0000, 1'b1, 1'b0};
    vecs[2] = '{64'h0000_001C_001C_0000, 9'h048, 9'h00C, 1'b0, 64'h0000_0808_0808_0800, 1'b0, 1'b0};
    vecs[3] = '{64'h0000_001C_001C_0000, 9'h008, 9'h00C, 1'b0, 64'h0000_0808_0008_0800, 1'b0, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_0038, 9'h008, 9'h00C, 1'b1, 64'h1000_0000_0000_1010, 1'b0, 1'b0};
    vecs[5] = '{64'h0000_0000_0000_0038, 9'h008, 9'h00C, 1'b0, 64'h0000_0000_0000_1010, 1'b0, 1'b0};
    vecs[6] = '{64'h0000_0101_0100_0000, 9'h008, 9'h00C, 1'b1, 64'h0000_0083_0000_0000, 1'b0, 1'b0};
    vecs[7] = '{64'h0, 9'h001, 9'h000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 9'h000, 9'h100, 1'b0, 64'h007E_7E7E_7E7E_7E00, 1'b0, 1'b0};

    #12;
    chk("rst_q", q_a, 64'h0);
    chk("rst_gen", {48'h0, gen_a}, 64'h0);
    chk("rst_flags", {60'h0, run_a, stable_a, extinct_a, run_b}, 64'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      birth_mask   = vecs[i].birth;
      survive_mask = vecs[i].survive;
      wrap         = vecs[i].wrap;
      data_a       = vecs[i].data;
      do_load();
      do_step();
      chk($sformatf("vec%0d_q", i), q_a, vecs[i].exp_q);
      chk($sformatf("vec%0d_stable", i), {63'h0, stable_a}, {63'h0, vecs[i].exp_stable});
      chk($sformatf("vec%0d_extinct", i), {63'h0, extinct_a}, {63'h0, vecs[i].exp_extinct});
      chk($sformatf("vec%0d_gen", i), {48'h0, gen_a}, 64'h1);
    end
    birth_mask = 9'h008;
    survive_mask = 9'h00C;
    wrap = 1'b0;

    // 5x5 blinker oscillates with period 2
    data_b = 25'h0003800;
    data_a = '0;
    do_load();
    do_step();
    chk("blinker_v", {39'h0, q_b}, 64'h21080);
    do_step();
    chk("blinker_h", {39'h0, q_b}, 64'h3800);
    chk("blinker_gen", {61'h0, gen_b}, 64'h2);
    chk("blinker_stable", {63'h0, stable_b}, 64'h0);

    // Lone cell: dies, then the empty grid is both stable and extinct
    data_a = 64'h0000_0000_0800_0000;
    do_load();
    do_step();
    chk("lone_extinct1", {62'h0, stable_a, extinct_a}, 64'h1);
    do_step();
    chk("lone_extinct2", {62'h0, stable_a, extinct_a}, 64'h3);
    chk("lone_gen", {48'h0, gen_a}, 64'h2);

    // start and step together: start wins, no update; stop returns to idle without update
    do_load();
    start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0;
    chk("startstep_run", {63'h0, run_a}, 64'h1);
    chk("startstep_q", q_a, 64'h0000_0000_0800_0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_q", q_a, 64'h0000_0000_0800_0000);
    chk("stop_state", {48'h0, gen_a} | {63'h0, run_a}, 64'h0);

    // Glider on 8x8 torus returns home after 32 generations
    wrap = 1'b1;
    data_a = 64'h0000_0000_0007_0402;
    do_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("glider_running", {63'h0, run_a}, 64'h1);
    chk("glider_start_q", q_a, 64'h0000_0000_0007_0402);
    repeat (32) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("glider_wrap_q", q_a, 64'h0000_0000_0007_0402);
    chk("glider_wrap_gen", {48'h0, gen_a}, 64'd32);
    chk("glider_stopped", {63'h0, run_a}, 64'h0);

    // Same glider with dead edges settles into a corner block
    wrap = 1'b0;
    do_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("glider_edge_q", q_a, 64'hC0C0_0000_0000_0000);
    chk("glider_edge_flags", {62'h0, stable_a, extinct_a}, 64'h2);
    chk("glider_edge_gen", {48'h0, gen_a}, 64'd30);

    // Block with auto_halt leaves RUN on the first update
    auto_halt = 1'b1;
    data_a = 64'h0000_0018_1800_0000;
    do_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_running", {63'h0, run_a}, 64'h1);
    tick();
    chk("halt_stopped", {62'h0, run_a, stable_a}, 64'h1);
    chk("halt_gen", {48'h0, gen_a}, 64'h1);
    chk("halt_q", q_a, 64'h0000_0018_1800_0000);
    auto_halt = 1'b0;

    // 3-bit counter saturates, then async reset mid-run
    data_b = 25'h0003800;
    do_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("sat_gen", {61'h0, gen_b}, 64'h7);
    chk("sat_running", {63'h0, run_b}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", {39'h0, q_b}, 64'h0);
    chk("arst_gen_run", {60'h0, gen_b, run_b}, 64'h0);
    #1;
    rst_n = 1'b1;
    tick();

    // load while running forces IDLE and replaces the grid
    data_b = 25'h0003800;
    do_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    data_b = 25'h1000001;
    do_load();
    chk("load_run", {63'h0, run_b}, 64'h0);
    chk("load_q", {39'h0, q_b}, 64'h1000001);
    chk("load_gen", {61'h0, gen_b}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
